fifo_uart_exerciser: RTL and testbench
======================================

# fifo_uart_exerciser

Parametrised successor to the single-width FIFO test driver: a UART-command-driven exerciser for an external synchronous FIFO of arbitrary word width. It fills the FIFO with an incrementing pattern, drains it word by word over the byte-wide UART TX path, checks every drained word against the expected sequence, and reports an error count on request. It sits between the UART RX/TX cores and the FIFO under test on the board top level.

## Interface

Parameters:
- DATA_BITS, 16: FIFO word width. Must be a multiple of 8, range 8..32.
- ERR_BITS, 8: error counter width, saturating. Status reply is the low 8 bits.

Ports:
- clk_in, in, 1: system clock. All logic is on the rising edge.
- n_rst, in, 1: reset. Asynchronous, active-low.
- uart_rx_valid_in, in, 1: one-cycle strobe marking a received command byte.
- uart_rx_data_in, in, 8: received command byte.
- uart_tx_ready_in, in, 1: high while the UART transmitter is idle.
- uart_tx_en, out, 1: one-cycle strobe to launch a byte.
- uart_tx_data_out, out, 8: byte to send. Held stable from the tx_en strobe until the next strobe.
- fifo_full_in, in, 1: FIFO full flag.
- fifo_empty_in, in, 1: FIFO empty flag.
- fifo_wr_en, out, 1: push strobe.
- fifo_wr_data_out, out, DATA_BITS: push data.
- fifo_rd_en, out, 1: pop strobe. The FIFO is first-word-fall-through, so fifo_rd_data_in is valid whenever the FIFO is not empty.
- fifo_rd_data_in, in, DATA_BITS: head-of-FIFO word.
- err_flag, out, 1: sticky. Set on the first compare mismatch; cleared only by 'c' or by reset.
- busy, out, 1: high while either FSM is outside its idle state.

## Operation

Commands are ASCII bytes qualified by uart_rx_valid_in. Any other byte is ignored, as is any command that arrives while its target FSM is busy.
- 'w': fill. Push words until fifo_full_in is seen.
- 'W': push a single word. Ignored if the FIFO is full.
- 'r': drain. Pop and send words until fifo_empty_in is seen.
- 'R': pop and send a single word. Ignored if the FIFO is empty.
- 's': send one status byte, err_cnt[7:0]. Executed by the read FSM.
- 'c': clear wr_cnt, exp_cnt, err_cnt and err_flag. Accepted only when both FSMs are idle.

Write FSM:
- States: WR_IDLE, WR_PUSH, WR_GAP.
- WR_PUSH: assert fifo_wr_en for one cycle with fifo_wr_data_out = wr_cnt, and increment wr_cnt.
- WR_GAP: fifo_wr_en = 0.
  - Fill mode and not full: go to WR_PUSH.
  - Otherwise: go to WR_IDLE.
- WR_PUSH re-checks fifo_full_in. If full, it skips the push and goes directly to WR_IDLE.
- wr_cnt is DATA_BITS wide and wraps modulo 2^DATA_BITS.

Read FSM:
- States: RD_IDLE, RD_POP, RD_SEND, RD_WAIT_BUSY, RD_WAIT_DONE.
- RD_POP:
  - Wait for uart_tx_ready_in and not empty.
  - Then latch fifo_rd_data_in into the shift register and pulse fifo_rd_en for one cycle.
  - Compare the latched word against exp_cnt. On mismatch, increment err_cnt (saturating) and set err_flag.
  - exp_cnt increments every pop, and wraps.
- RD_SEND:
  - Pulse uart_tx_en with the most significant remaining byte.
  - Bytes go MSB first, DATA_BITS/8 bytes per word.
- RD_WAIT_BUSY: wait for uart_tx_ready_in to go low.
- RD_WAIT_DONE: wait for uart_tx_ready_in to go high. Then:
  - More bytes remain: go to RD_SEND.
  - Drain mode and not empty: go to RD_POP.
  - Otherwise: go to RD_IDLE.
- A status command 's' loads err_cnt[7:0] as a one-byte word and enters RD_SEND directly. It performs no pop and no compare.

The two FSMs are independent and may run concurrently, e.g. 'r' issued during an ongoing 'w' fill.

Reset values:
- All outputs are 0.
- Both FSMs are idle.
- All counters and the shift register are 0.
- Reset mid-operation aborts immediately. A strobe that was high goes low asynchronously.

## Timing

- Command byte to first fifo_wr_en: 2 cycles. The command is registered into WR_PUSH on the edge after rx_valid, and the strobe is issued in WR_PUSH.
- In fill mode, pushes occur every 2 cycles (one push per WR_PUSH/WR_GAP pair).
- Command to first fifo_rd_en: 2 cycles, provided tx is ready and the FIFO is not empty.
- fifo_rd_en to the first uart_tx_en: 1 cycle.
- fifo_wr_en, fifo_rd_en and uart_tx_en are single-cycle pulses, never asserted back-to-back.
- A FIFO that becomes full or empty exactly in WR_GAP or RD_WAIT_DONE ends the fill or drain cleanly, with no extra strobe.

## Structure

- Shared package fifo_exer_pkg holds:
  - the command byte constants: CMD_FILL, CMD_PUSH1, CMD_DRAIN, CMD_POP1, CMD_STAT, CMD_CLR;
  - the write-state and read-state encodings as 2-bit and 3-bit localparams/typedefs.
- One natural sub-module is fifo_tx_serializer. It owns the byte shift register and index, and runs the RD_SEND/RD_WAIT_BUSY/RD_WAIT_DONE handshake.
  - Inputs: a word-load strobe and a byte count.
  - Output: a done strobe.

## Test plan

All scenarios use DATA_BITS=16, a FIFO of depth 4, and a UART model with ready low for 10 cycles after each tx_en.

- 'w' on an empty FIFO:
  - Required: exactly 4 pushes, with data 0x0000..0x0003.
  - Required: busy drops after full is seen, with no fifth wr_en.
- After fill, 'r':
  - Required: 4 pops and 8 tx bytes in the order 00 00 00 01 00 02 00 03.
  - Required: err_flag stays 0 and the FSM returns to RD_IDLE.
- Corrupt the second word to 0xBEEF, then 'r' followed by 's':
  - Required: err_flag = 1 after the second pop.
  - Required: the status byte is 0x01.
- 'W' with the FIFO full, and 'R' with it empty: required to produce no strobes. Unknown byte 'x': ignored.
- 'c' sent while a fill is in progress: required to be ignored. 'c' sent when both FSMs are idle:
  - Required: err_flag cleared.
  - Required: the next 'W' pushes 0x0000.
- n_rst asserted during RD_WAIT_BUSY of a drain:
  - Required: all outputs 0 immediately.
  - Required: a subsequent 'r' restarts with exp_cnt = 0.

Source files
------------

// File: rtl/fifo_exer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_exer_pkg: command bytes and FSM encodings for the FIFO exerciser  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fifo_exer_pkg;

  localparam logic [7:0] CMD_FILL  = 8'h77;  // 'w'
  localparam logic [7:0] CMD_PUSH1 = 8'h57;  // 'W'
  localparam logic [7:0] CMD_DRAIN = 8'h72;  // 'r'
  localparam logic [7:0] CMD_POP1  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STAT  = 8'h73;  // 's'
  localparam logic [7:0] CMD_CLR   = 8'h63;  // 'c'

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PUSH = 2'd1,
    WR_GAP  = 2'd2
  } wr_state_t;

  typedef enum logic [2:0] {
    RD_IDLE      = 3'd0,
    RD_POP       = 3'd1,
    RD_SEND      = 3'd2,
    RD_WAIT_BUSY = 3'd3,
    RD_WAIT_DONE = 3'd4
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_tx_serializer: sends a loaded word MSB-first over the UART TX    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fifo_tx_serializer
  import fifo_exer_pkg::*;
#(
  parameter int DATA_BITS = 16
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 load_i,
  input  logic [DATA_BITS-1:0] word_i,
  input  logic [CNT_W-1:0]     nbytes_i,
  input  logic                 tx_ready_i,
  output logic                 tx_en_o,
  output logic [7:0]           tx_data_o,
  output logic                 done_o
);

  rd_state_t              state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [CNT_W-1:0]       left_q;
  logic                   tx_en_q;
  logic [7:0]             tx_data_q;

  assign tx_en_o   = tx_en_q;
  assign tx_data_o = tx_data_q;
  assign done_o    = (state_q == RD_WAIT_DONE) && tx_ready_i && (left_q == '0);

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= RD_IDLE;
      shift_q   <= '0;
      left_q    <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      case (state_q)
        RD_SEND: begin
          tx_en_q   <= 1'b1;
          tx_data_q <= shift_q[DATA_BITS-1 -: 8];
          shift_q   <= shift_q << 8;
          left_q    <= left_q - CNT_W'(1);
          state_q   <= RD_WAIT_BUSY;
        end
        RD_WAIT_BUSY: begin
          tx_en_q <= 1'b0;
          if (!tx_ready_i) state_q <= RD_WAIT_DONE;
        end
        RD_WAIT_DONE: begin
          if (tx_ready_i) state_q <= (left_q != '0) ? RD_SEND : RD_IDLE;
        end
        default: begin
          tx_en_q <= 1'b0;
          if (load_i) begin
            shift_q <= word_i;
            left_q  <= nbytes_i;
            state_q <= RD_SEND;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_exerciser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_uart_exerciser: UART-driven fill/drain/check of an external FIFO |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fifo_uart_exerciser
  import fifo_exer_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter int ERR_BITS  = 8
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 uart_rx_valid_in,
  input  logic [7:0]           uart_rx_data_in,
  input  logic                 uart_tx_ready_in,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data_out,
  input  logic                 fifo_full_in,
  input  logic                 fifo_empty_in,
  output logic                 fifo_wr_en,
  output logic [DATA_BITS-1:0] fifo_wr_data_out,
  output logic                 fifo_rd_en,
  input  logic [DATA_BITS-1:0] fifo_rd_data_in,
  output logic                 err_flag,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] WORD_BYTES = CNT_W'(DATA_BITS / 8);

  wr_state_t              wr_state_q;
  logic                   fill_q;
  logic [DATA_BITS-1:0]   wr_cnt_q;
  logic [DATA_BITS-1:0]   wr_data_q;
  logic                   wr_en_q;

  rd_state_t              rd_state_q;
  logic                   drain_q;
  logic [DATA_BITS-1:0]   exp_cnt_q;
  logic [ERR_BITS-1:0]    err_cnt_q;
  logic                   err_flag_q;
  logic                   rd_en_q;

  logic                   wr_idle, rd_idle, cmd_clr, stat_go, pop_fire;
  logic                   ser_load, ser_done;
  logic [7:0]             stat_byte;
  logic [DATA_BITS-1:0]   ser_word;
  logic [CNT_W-1:0]       ser_nbytes;

  assign wr_idle    = (wr_state_q == WR_IDLE);
  assign rd_idle    = (rd_state_q == RD_IDLE);
  assign cmd_clr    = uart_rx_valid_in && (uart_rx_data_in == CMD_CLR) && wr_idle && rd_idle;
  assign stat_go    = uart_rx_valid_in && (uart_rx_data_in == CMD_STAT) && rd_idle;
  assign pop_fire   = (rd_state_q == RD_POP) && uart_tx_ready_in && !fifo_empty_in;
  assign stat_byte  = 8'(err_cnt_q);
  // Status byte rides in the top byte so the serializer's MSB-first path sends it.
  assign ser_word   = pop_fire ? fifo_rd_data_in : (DATA_BITS'(stat_byte) << (DATA_BITS - 8));
  assign ser_nbytes = pop_fire ? WORD_BYTES : CNT_W'(1);
  assign ser_load   = pop_fire || stat_go;

  assign fifo_wr_en       = wr_en_q;
  assign fifo_wr_data_out = wr_data_q;
  assign fifo_rd_en       = rd_en_q;
  assign err_flag         = err_flag_q;
  assign busy             = !wr_idle || !rd_idle;

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      wr_state_q <= WR_IDLE;
      fill_q     <= 1'b0;
      wr_cnt_q   <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      case (wr_state_q)
        WR_PUSH: begin
          if (fifo_full_in) begin
            wr_state_q <= WR_IDLE;
          end else begin
            wr_en_q    <= 1'b1;
            wr_data_q  <= wr_cnt_q;
            wr_cnt_q   <= wr_cnt_q + DATA_BITS'(1);
            wr_state_q <= WR_GAP;
          end
        end
        WR_GAP: begin
          wr_en_q    <= 1'b0;
          wr_state_q <= (fill_q && !fifo_full_in) ? WR_PUSH : WR_IDLE;
        end
        default: begin
          wr_en_q <= 1'b0;
          if (cmd_clr) begin
            wr_cnt_q <= '0;
          end else if (uart_rx_valid_in && uart_rx_data_in == CMD_FILL) begin
            fill_q     <= 1'b1;
            wr_state_q <= WR_PUSH;
          end else if (uart_rx_valid_in && uart_rx_data_in == CMD_PUSH1 && !fifo_full_in) begin
            fill_q     <= 1'b0;
            wr_state_q <= WR_PUSH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      rd_state_q <= RD_IDLE;
      drain_q    <= 1'b0;
      exp_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      case (rd_state_q)
        RD_POP: begin
          if (pop_fire) begin
            rd_en_q    <= 1'b1;
            exp_cnt_q  <= exp_cnt_q + DATA_BITS'(1);
            rd_state_q <= RD_SEND;
            if (fifo_rd_data_in != exp_cnt_q) begin
              err_flag_q <= 1'b1;
              if (err_cnt_q != {ERR_BITS{1'b1}}) err_cnt_q <= err_cnt_q + ERR_BITS'(1);
            end
          end
        end
        RD_SEND: begin
          rd_en_q <= 1'b0;
          if (ser_done) rd_state_q <= (drain_q && !fifo_empty_in) ? RD_POP : RD_IDLE;
        end
        default: begin
          rd_en_q <= 1'b0;
          if (cmd_clr) begin
            exp_cnt_q  <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
          end else if (stat_go) begin
            drain_q    <= 1'b0;
            rd_state_q <= RD_SEND;
          end else if (uart_rx_valid_in && uart_rx_data_in == CMD_DRAIN) begin
            drain_q    <= 1'b1;
            rd_state_q <= RD_POP;
          end else if (uart_rx_valid_in && uart_rx_data_in == CMD_POP1 && !fifo_empty_in) begin
            drain_q    <= 1'b0;
            rd_state_q <= RD_POP;
          end
        end
      endcase
    end
  end

  fifo_tx_serializer #(
    .DATA_BITS (DATA_BITS)
  ) u_ser (
    .clk_in     (clk_in),
    .n_rst      (n_rst),
    .load_i     (ser_load),
    .word_i     (ser_word),
    .nbytes_i   (ser_nbytes),
    .tx_ready_i (uart_tx_ready_in),
    .tx_en_o    (uart_tx_en),
    .tx_data_o  (uart_tx_data_out),
    .done_o     (ser_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_exerciser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_uart_exerciser: depth-4 FWFT FIFO and slow UART around the DUT |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fifo_uart_exerciser;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        full, empty;
  logic        wr_en, rd_en;
  logic [15:0] wr_data, rd_data;
  logic        err_flag, busy;

  always #5 clk = ~clk;

  fifo_uart_exerciser #(.DATA_BITS(16), .ERR_BITS(8)) dut (
    .clk_in           (clk),
    .n_rst            (n_rst),
    .uart_rx_valid_in (rx_valid),
    .uart_rx_data_in  (rx_data),
    .uart_tx_ready_in (tx_ready),
    .uart_tx_en       (tx_en),
    .uart_tx_data_out (tx_data),
    .fifo_full_in     (full),
    .fifo_empty_in    (empty),
    .fifo_wr_en       (wr_en),
    .fifo_wr_data_out (wr_data),
    .fifo_rd_en       (rd_en),
    .fifo_rd_data_in  (rd_data),
    .err_flag         (err_flag),
    .busy             (busy)
  );

  // Depth-4 first-word-fall-through FIFO, sharing the board reset.
  logic [15:0] mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  cnt;
  logic        corrupt_req = 1'b0;
  logic        push, pop;
  assign full    = (cnt == 3'd4);
  assign empty   = (cnt == 3'd0);
  assign rd_data = mem[rp];
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wp <= '0; rp <= '0; cnt <= '0;
    end else begin
      if (push) begin mem[wp] <= wr_data; wp <= wp + 2'd1; end
      if (corrupt_req) mem[rp + 2'd1] <= 16'hBEEF;
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + {2'b00, push} - {2'b00, pop};
    end
  end

  // UART transmitter: busy for 10 cycles after each launch.
  int ubusy = 0;
  assign tx_ready = (ubusy == 0);
  always @(posedge clk) begin
    if (tx_en) ubusy <= 10;
    else if (ubusy != 0) ubusy <= ubusy - 1;
  end

  logic        log_clr = 1'b0;
  int          n_wr = 0, n_tx = 0, n_pop = 0, b2b = 0;
  logic [63:0] wr_pack = '0, tx_pack = '0;
  logic [3:0]  pop_flags = '0;
  logic        prev_wr = 1'b0, prev_rd = 1'b0, prev_tx = 1'b0;

  always @(negedge clk) begin
    if (log_clr) begin
      n_wr <= 0; n_tx <= 0; n_pop <= 0;
      wr_pack <= '0; tx_pack <= '0; pop_flags <= '0;
    end else begin
      if (wr_en) begin n_wr <= n_wr + 1; wr_pack <= {wr_pack[47:0], wr_data}; end
      if (tx_en) begin n_tx <= n_tx + 1; tx_pack <= {tx_pack[55:0], tx_data}; end
      if (rd_en) begin n_pop <= n_pop + 1; pop_flags <= {pop_flags[2:0], err_flag}; end
    end
    if ((wr_en && prev_wr) || (rd_en && prev_rd) || (tx_en && prev_tx)) b2b <= b2b + 1;
    prev_wr <= wr_en; prev_rd <= rd_en; prev_tx <= tx_en;
  end

  int tests = 0, fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    repeat (4) @(negedge clk);
    while (busy && k < 3000) begin @(negedge clk); k++; end
    if (busy) check({nm, "_timeout"}, 64'(busy), 64'd0);
    repeat (14) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  cmd2;
    int          dly2;
    bit          corrupt;
    int          n_wr;
    logic [63:0] wr_pack;
    int          n_tx;
    logic [63:0] tx_pack;
    int          n_pop;
    logic [3:0]  pop_flags;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    string s = $sformatf("v%0d", i);
    @(negedge clk); #1 log_clr = 1'b1;
    @(negedge clk); #1 log_clr = 1'b0;
    if (v.corrupt) begin
      corrupt_req = 1'b1;
      @(posedge clk); #1 corrupt_req = 1'b0;
    end
    send_cmd(v.cmd);
    if (v.dly2 > 0) begin
      repeat (v.dly2) @(negedge clk);
      send_cmd(v.cmd2);
    end
    wait_idle(s);
    check({s, "_nwr"},   64'(n_wr),      64'(v.n_wr));
    check({s, "_wrdat"}, wr_pack,        v.wr_pack);
    check({s, "_ntx"},   64'(n_tx),      64'(v.n_tx));
    check({s, "_txdat"}, tx_pack,        v.tx_pack);
    check({s, "_npop"},  64'(n_pop),     64'(v.n_pop));
    check({s, "_popf"},  64'(pop_flags), 64'(v.pop_flags));
    check({s, "_err"},   64'(err_flag),  64'(v.err));
  endtask

  initial begin
    //         cmd    cmd2   dly cor nwr wr_pack                nt tx_pack                np pf    err
    vecs[0]  = '{8'h77, 8'h00, 0, 0, 4, 64'h0000_0001_0002_0003, 0, 64'h0,                 0, 4'h0, 1'b0};
    vecs[1]  = '{8'h57, 8'h00, 0, 0, 0, 64'h0,                 0, 64'h0,                 0, 4'h0, 1'b0};
    vecs[2]  = '{8'h78, 8'h00, 0, 0, 0, 64'h0,                 0, 64'h0,                 0, 4'h0, 1'b0};
    vecs[3]  = '{8'h72, 8'h00, 0, 0, 0, 64'h0,                 8, 64'h0000_0001_0002_0003, 4, 4'h0, 1'b0};
    vecs[4]  = '{8'h52, 8'h00, 0, 0, 0, 64'h0,                 0, 64'h0,                 0, 4'h0, 1'b0};
    vecs[5]  = '{8'h77, 8'h00, 0, 0, 4, 64'h0004_0005_0006_0007, 0, 64'h0,                 0, 4'h0, 1'b0};
    vecs[6]  = '{8'h72, 8'h00, 0, 1, 0, 64'h0,                 8, 64'h0004_BEEF_0006_0007, 4, 4'h7, 1'b1};
    vecs[7]  = '{8'h73, 8'h00, 0, 0, 0, 64'h0,                 1, 64'h01,                0, 4'h0, 1'b1};
    vecs[8]  = '{8'h63, 8'h00, 0, 0, 0, 64'h0,                 0, 64'h0,                 0, 4'h0, 1'b0};
    vecs[9]  = '{8'h57, 8'h00, 0, 0, 1, 64'h0,                 0, 64'h0,                 0, 4'h0, 1'b0};
    vecs[10] = '{8'h72, 8'h00, 0, 0, 0, 64'h0,                 2, 64'h0,                 1, 4'h0, 1'b0};
    vecs[11] = '{8'h77, 8'h63, 3, 0, 4, 64'h0001_0002_0003_0004, 0, 64'h0,                 0, 4'h0, 1'b0};
    vecs[12] = '{8'h72, 8'h00, 0, 0, 0, 64'h0,                 8, 64'h0001_0002_0003_0004, 4, 4'h0, 1'b0};
    vecs[13] = '{8'h77, 8'h00, 0, 0, 4, 64'h0000_0001_0002_0003, 0, 64'h0,                 0, 4'h0, 1'b0};
    vecs[14] = '{8'h72, 8'h00, 0, 0, 0, 64'h0,                 8, 64'h0000_0001_0002_0003, 4, 4'h0, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_in", 64'({tx_en, tx_data, wr_en, wr_data, rd_en, err_flag, busy}), 64'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out", 64'({tx_en, tx_data, wr_en, wr_data, rd_en, err_flag, busy}), 64'd0);

    for (int i = 0; i <= 12; i++) run_vec(i);

    // Abort a drain while the serializer waits for the UART to go busy.
    send_cmd(8'h77);
    wait_idle("rst_fill");
    send_cmd(8'h72);
    begin
      int k = 0;
      while (!tx_en && k < 200) begin @(negedge clk); k++; end
    end
    check("rst_pre_txen", 64'(tx_en), 64'd1);
    n_rst = 1'b0;
    #1;
    check("rst_async", 64'({tx_en, tx_data, wr_en, wr_data, rd_en, err_flag, busy}), 64'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (15) @(negedge clk);

    for (int i = 13; i <= 14; i++) run_vec(i);

    check("no_b2b_strobes", 64'(b2b), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
